uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 118 +++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. The line is synchronized, the start bit is
// confirmed at its midpoint, and each data/stop bit is sampled one bit period
// later so sampling lands near the centre of every bit.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       serial_in,
    output logic [7:0] rx_buf,
    output logic       done,
    output logic       busy,
    output logic       frame_err
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0] HALF_TICK = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] FULL_TICK = TIMER_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [2:0]         bit_idx;
    logic [7:0]         shift_reg;
    logic               sync_ff;
    logic               rx_s;

    // Two-flop synchronizer; resets to the idle-high line level so no false start appears.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync_ff <= serial_in;
            rx_s    <= sync_ff;
        end
    end

    // Frame state machine: start detection, mid-bit sampling, stop check and output pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            rx_buf    <= 8'h00;
            done      <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done      <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && !rx_s) begin
                        state <= START;
                        timer <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (timer == HALF_TICK) begin
                        timer <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == FULL_TICK) begin
                        timer              <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (timer == FULL_TICK) begin
                        timer <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (rx_s) begin
                            rx_buf <= shift_reg;
                            done   <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
